// File: rtl/ysyx_23060201_mem_arb_pkg.sv
// Shared definitions for the IFU/LSU memory-port arbiter.
//   state_t   : sequencer states (IDLE -> ISSUE -> WAIT -> RESP -> IDLE)
//   OWN_*     : encoding of the requester that owns the current transaction
//   IFU_MASK  : byte mask presented downstream for every instruction fetch
package ysyx_23060201_mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int          MASK_W   = 8;
    localparam logic [7:0]  IFU_MASK = 8'h0f;

endpackage

// File: rtl/ysyx_23060201_rr_arb2.sv
// Combinational two-way round-robin grant.
//   req[0] : IFU request, req[1] : LSU request
//   last   : owner of the most recent grant (OWN_IFU / OWN_LSU)
//   gnt    : one-hot grant, all zero when nobody requests
// On a tie the requester that was not granted last wins.
module ysyx_23060201_rr_arb2
    import ysyx_23060201_mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == OWN_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_23060201_mem_arb.sv
// Arbiter and sequencer sharing one memory port between the IFU (read only)
// and the LSU (read/write). One downstream transaction at a time:
//   IDLE  : round-robin grant, request fields latched on handshake
//   ISSUE : mem_req_valid held with the latched fields until mem_req_ready
//   WAIT  : wait for mem_resp_valid, give up after TIMEOUT+1 cycles
//   RESP  : one-cycle response pulse to the owning requester
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifu_req_valid/ready, ifu_addr      IFU request channel
//   ifu_resp_valid, ifu_rdata          IFU response
//   lsu_req_valid/ready, lsu_wen,
//   lsu_addr, lsu_wdata, lsu_mask      LSU request channel
//   lsu_resp_valid, lsu_rdata          LSU response (rdata 0 for writes)
//   mem_req_valid/ready, mem_wen,
//   mem_addr, mem_wdata, mem_mask      downstream request
//   mem_resp_valid, mem_rdata          downstream completion
//   err                                sticky timeout flag
module ysyx_23060201_mem_arb
    import ysyx_23060201_mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [MASK_W-1:0]     lsu_mask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_W-1:0]     mem_mask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  err
);

    localparam int              CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t                state_reg, state_next;
    logic                  last_reg;
    logic                  owner_reg;
    logic                  wen_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [MASK_W-1:0]     mask_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  err_reg;
    logic [DATA_WIDTH-1:0] ifu_rdata_reg;
    logic [DATA_WIDTH-1:0] lsu_rdata_reg;

    logic [1:0]            gnt;
    logic                  accept;
    logic                  wait_done;
    logic [DATA_WIDTH-1:0] resp_data;

    ysyx_23060201_rr_arb2 u_rr_arb2 (
        .req  ({lsu_req_valid, ifu_req_valid}),
        .last (last_reg),
        .gnt  (gnt)
    );

    assign accept    = ifu_req_ready | lsu_req_ready;
    // A response arriving on the very cycle the counter expires still wins.
    assign wait_done = mem_resp_valid || (cnt_reg == TIMEOUT_C);
    // Writes and timeouts both return zero data.
    assign resp_data = (mem_resp_valid && !wen_reg) ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Gated by rst_n so ready reads 0 while reset is held even
                // though the grant path is purely combinational.
                ifu_req_ready = rst_n & gnt[0];
                lsu_req_ready = rst_n & gnt[1];
                if (|gnt) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_done) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                ifu_resp_valid = (owner_reg == OWN_IFU);
                lsu_resp_valid = (owner_reg == OWN_LSU);
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request latch: captured once per transaction, held stable downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg  <= OWN_LSU;
            owner_reg <= OWN_IFU;
            wen_reg   <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            mask_reg  <= '0;
        end else if (accept) begin
            if (lsu_req_ready) begin
                last_reg  <= OWN_LSU;
                owner_reg <= OWN_LSU;
                wen_reg   <= lsu_wen;
                addr_reg  <= lsu_addr;
                wdata_reg <= lsu_wdata;
                mask_reg  <= lsu_mask;
            end else begin
                last_reg  <= OWN_IFU;
                owner_reg <= OWN_IFU;
                wen_reg   <= 1'b0;
                addr_reg  <= ifu_addr;
                wdata_reg <= '0;
                mask_reg  <= IFU_MASK;
            end
        end
    end

    // Timeout counter, sticky error and per-requester response data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            err_reg       <= 1'b0;
            ifu_rdata_reg <= '0;
            lsu_rdata_reg <= '0;
        end else begin
            case (state_reg)
                ST_ISSUE: cnt_reg <= '0;
                ST_WAIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (wait_done) begin
                        if (owner_reg == OWN_IFU) begin
                            ifu_rdata_reg <= resp_data;
                        end else begin
                            lsu_rdata_reg <= resp_data;
                        end
                        if (!mem_resp_valid) begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wen   = wen_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_mask  = mask_reg;
    assign ifu_rdata = ifu_rdata_reg;
    assign lsu_rdata = lsu_rdata_reg;
    assign err       = err_reg;

endmodule
